// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared widths, IV constant and FSM states for the SHA-256 state bank
package sha256_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 8;

   // Word i of the chaining value sits at index i, so IV[0] is H0.
   localparam logic [NUM_WORDS-1:0][WORD_W-1:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/hash_word_acc.sv
// rtl/hash_word_acc.sv - one 32-bit chaining word: IV load, modular add, hold
module hash_word_acc
   import sha256_pkg::*;
#(
   parameter logic [WORD_W-1:0] INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_iv,
   input  logic              add_en,
   input  logic [WORD_W-1:0] addend,
   output logic [WORD_W-1:0] word,
   output logic [WORD_W-1:0] sum
);

   logic [WORD_W-1:0] word_q;

   assign sum  = word_q + addend;
   assign word = word_q;

   // IV reload wins over add so a double-hash hand-over restarts from IV.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= INIT;
      end else if (load_iv) begin
         word_q <= INIT;
      end else if (add_en) begin
         word_q <= sum;
      end
   end

endmodule

// File: rtl/sha256_state_bank.sv
// rtl/sha256_state_bank.sv - SHA-256 chaining state bank with optional double-hash pass
module sha256_state_bank
   import sha256_pkg::*;
#(
   parameter int MAX_BLOCKS     = 4,
   parameter bit DOUBLE_SUPPORT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [3:0]   nblocks,
   input  logic         double_en,
   input  logic         work_valid,
   input  logic [255:0] work_in,
   output logic         work_ready,
   output logic [255:0] chain_out,
   output logic [255:0] mid_out,
   output logic         phase,
   output logic [255:0] digest_out,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic         busy,
   output logic         err
);

   localparam logic [3:0] MAX_NB = 4'(MAX_BLOCKS);

   state_t       state, state_nx;
   logic [3:0]   nblk_q, blk_cnt;
   logic         dbl_q;
   logic [255:0] sum_all;
   logic         accept, start_ok, last_blk, load_iv;

   assign accept   = work_ready & work_valid;
   assign start_ok = (nblocks != 4'd0) && (nblocks <= MAX_NB);
   assign last_blk = (blk_cnt == nblk_q - 4'd1);
   assign load_iv  = ((state == ST_PASS1) && accept && last_blk && dbl_q) ||
                     ((state == ST_DONE) && digest_ready);

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_acc
      hash_word_acc #(.INIT(IV[g])) u_acc (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_iv (load_iv),
         .add_en  (accept),
         .addend  (work_in[g*WORD_W +: WORD_W]),
         .word    (chain_out[g*WORD_W +: WORD_W]),
         .sum     (sum_all[g*WORD_W +: WORD_W])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start && start_ok) state_nx = ST_PASS1;
         ST_PASS1: if (accept && last_blk) state_nx = dbl_q ? ST_PASS2 : ST_DONE;
         ST_PASS2: if (accept) state_nx = ST_DONE;
         ST_DONE:  if (digest_ready) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      work_ready   = (state == ST_PASS1) || (state == ST_PASS2);
      busy         = (state != ST_IDLE);
      digest_valid = (state == ST_DONE);
   end

   // Message bookkeeping and the two result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nblk_q     <= 4'd0;
         blk_cnt    <= 4'd0;
         dbl_q      <= 1'b0;
         phase      <= 1'b0;
         mid_out    <= '0;
         digest_out <= '0;
         err        <= 1'b0;
      end else begin
         err <= (state == ST_IDLE) && start && !start_ok;
         case (state)
            ST_IDLE: begin
               if (start && start_ok) begin
                  nblk_q  <= nblocks;
                  dbl_q   <= double_en & DOUBLE_SUPPORT;
                  blk_cnt <= 4'd0;
               end
            end
            ST_PASS1: begin
               if (accept) begin
                  if (!last_blk) begin
                     blk_cnt <= blk_cnt + 4'd1;
                  end else if (dbl_q) begin
                     mid_out <= sum_all;
                     phase   <= 1'b1;
                  end else begin
                     digest_out <= sum_all;
                  end
               end
            end
            ST_PASS2: begin
               if (accept) digest_out <= sum_all;
            end
            ST_DONE: begin
               if (digest_ready) phase <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_state_bank.sv
// tb/tb_sha256_state_bank.sv - self-checking bench with message-level reference model
module tb_sha256_state_bank;

   localparam logic [255:0] IV_LIT = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   nblocks = 4'd0;
   logic         double_en = 1'b0;
   logic         work_valid = 1'b0;
   logic [255:0] work_in = '0;
   logic         work_ready;
   logic [255:0] chain_out, mid_out, digest_out;
   logic         phase, digest_valid, busy, err;
   logic         digest_ready = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sha256_state_bank #(.MAX_BLOCKS(4), .DOUBLE_SUPPORT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .nblocks      (nblocks),
      .double_en    (double_en),
      .work_valid   (work_valid),
      .work_in      (work_in),
      .work_ready   (work_ready),
      .chain_out    (chain_out),
      .mid_out      (mid_out),
      .phase        (phase),
      .digest_out   (digest_out),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .busy         (busy),
      .err          (err)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
      return r;
   endfunction

   // Reference model: a message is a run of first-pass beats, optionally
   // followed by one second-pass beat, then a digest waiting for acceptance.
   logic [255:0] m_chain, m_mid, m_dig;
   bit           m_active, m_second, m_done, m_dbl, m_phase, m_err;
   int           m_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_chain <= IV_LIT; m_mid <= '0; m_dig <= '0;
         m_active <= 0; m_second <= 0; m_done <= 0; m_dbl <= 0;
         m_phase <= 0; m_err <= 0; m_left <= 0;
      end else begin
         m_err <= 0;
         if (!m_active && !m_done) begin
            if (start) begin
               if (nblocks >= 1 && nblocks <= 4) begin
                  m_active <= 1; m_second <= 0; m_left <= int'(nblocks); m_dbl <= double_en;
               end else begin
                  m_err <= 1;
               end
            end
         end else if (m_active && work_valid) begin
            if (!m_second && m_left > 1) begin
               m_chain <= add_words(m_chain, work_in);
               m_left  <= m_left - 1;
            end else if (!m_second && m_dbl) begin
               m_mid <= add_words(m_chain, work_in);
               m_chain <= IV_LIT; m_second <= 1; m_phase <= 1;
            end else begin
               m_dig <= add_words(m_chain, work_in);
               m_chain <= add_words(m_chain, work_in);
               m_active <= 0; m_done <= 1;
            end
         end else if (m_done && digest_ready) begin
            m_done <= 0; m_chain <= IV_LIT; m_phase <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("chain_out", chain_out, m_chain);
         chk("work_ready", 256'(work_ready), 256'(m_active));
         chk("busy", 256'(busy), 256'(m_active || m_done));
         chk("digest_valid", 256'(digest_valid), 256'(m_done));
         chk("digest_out", digest_out, m_dig);
         chk("mid_out", mid_out, m_mid);
         chk("phase", 256'(phase), 256'(m_phase));
         chk("err", 256'(err), 256'(m_err));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start = 0; nblocks = 0; double_en = 0; work_valid = 0; work_in = '0; digest_ready = 0;
   endtask

   initial begin
      tick(); tick();
      chk("rst_chain", chain_out, IV_LIT);
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_digest", digest_out, 256'(0));
      rst_n = 1;

      // Single block of zeros: digest equals IV, valid one cycle after the beat.
      tick(); start = 1; nblocks = 1; double_en = 0;
      tick(); start = 0; work_valid = 1; work_in = '0;
      chk("t1_ready", 256'(work_ready), 256'(1));
      tick(); work_valid = 0;
      chk("t1_valid", 256'(digest_valid), 256'(1));
      chk("t1_digest", digest_out, IV_LIT);
      digest_ready = 1;
      tick(); digest_ready = 0;
      chk("t1_idle", 256'(busy), 256'(0));

      // Word7 wraps to zero.
      start = 1; nblocks = 1;
      tick(); start = 0; work_valid = 1; work_in = {32'ha41f32e7, 224'd0};
      tick(); work_valid = 0;
      chk("t2_digest", digest_out, {32'h00000000, IV_LIT[223:0]});
      digest_ready = 1;
      tick(); digest_ready = 0;

      // Two first-pass blocks then the second pass, all-ones words.
      start = 1; nblocks = 2; double_en = 1;
      tick(); start = 0; double_en = 0; work_valid = 1; work_in = '1;
      tick();
      tick();
      chk("t3_phase", 256'(phase), 256'(1));
      chk("t3_mid_w0", 256'(mid_out[31:0]), 256'(32'h6a09e665));
      chk("t3_mid_w7", 256'(mid_out[255:224]), 256'(32'h5be0cd17));
      chk("t3_chain_iv", chain_out, IV_LIT);
      tick(); work_valid = 0;
      chk("t3_dig_w0", 256'(digest_out[31:0]), 256'(32'h6a09e666));
      chk("t3_dig_w7", 256'(digest_out[255:224]), 256'(32'h5be0cd18));
      chk("t3_valid", 256'(digest_valid), 256'(1));
      digest_ready = 1;
      tick(); digest_ready = 0;

      // Illegal block counts.
      for (int k = 0; k < 2; k++) begin
         start = 1; nblocks = (k == 0) ? 4'd0 : 4'd5;
         tick(); start = 0;
         chk("t4_err", 256'(err), 256'(1));
         chk("t4_busy", 256'(busy), 256'(0));
         tick();
         chk("t4_err_clr", 256'(err), 256'(0));
         chk("t4_busy2", 256'(busy), 256'(0));
      end

      // Digest held in DONE while start and work beats are ignored.
      start = 1; nblocks = 1;
      tick(); start = 0; work_valid = 1; work_in = {8{32'h00000001}};
      tick();
      for (int k = 0; k < 5; k++) begin
         start = 1; nblocks = 1; work_valid = 1; work_in = {$urandom, $urandom, $urandom, $urandom,
                                                           $urandom, $urandom, $urandom, $urandom};
         chk("t5_valid", 256'(digest_valid), 256'(1));
         chk("t5_dig_w0", 256'(digest_out[31:0]), 256'(32'h6a09e668));
         chk("t5_chain_w0", 256'(chain_out[31:0]), 256'(32'h6a09e668));
         tick();
      end
      work_valid = 0; digest_ready = 1;
      tick(); start = 0; digest_ready = 0;
      chk("t5_idle", 256'(busy), 256'(0));
      chk("t5_chain_iv", chain_out, IV_LIT);

      // Reset during the second pass.
      start = 1; nblocks = 1; double_en = 1;
      tick(); start = 0; double_en = 0; work_valid = 1; work_in = {8{32'h12345678}};
      tick(); work_valid = 0;
      chk("t6_phase", 256'(phase), 256'(1));
      #1 rst_n = 0;
      #1;
      chk("t6_chain", chain_out, IV_LIT);
      chk("t6_mid", mid_out, 256'(0));
      chk("t6_digest", digest_out, 256'(0));
      chk("t6_flags", 256'({phase, busy, work_ready, digest_valid, err}), 256'(0));
      tick(); rst_n = 1;
      tick(); start = 1; nblocks = 1;
      tick(); start = 0; work_valid = 1; work_in = '0;
      tick(); work_valid = 0;
      chk("t6_digest2", digest_out, IV_LIT);
      digest_ready = 1;
      tick(); idle_inputs();

      // Random traffic, checked every cycle by the model.
      repeat (3000) begin
         tick();
         start        = ($urandom_range(0, 3) == 0);
         nblocks      = 4'($urandom_range(0, 6));
         double_en    = 1'($urandom_range(0, 1));
         work_valid   = 1'($urandom_range(0, 1));
         work_in      = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
         digest_ready = ($urandom_range(0, 2) == 0);
      end
      tick(); idle_inputs();
      tick(); tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sha256_state_bank.md
SHA256_STATE_BANK -- requirements
Module: sha256_state_bank

Interface
REQ-001 SHALL have parameter MAX_BLOCKS, default 4, meaning the maximum number of 512-bit blocks in the first-pass message (range 1..15).
REQ-002 SHALL have parameter DOUBLE_SUPPORT, default 1, meaning the double-hash (SHA-256d) mode is built in; when it is 0, double_en is ignored.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a new message when the block is idle.
REQ-006 SHALL have port nblocks, input, 4 bits: block count for the first pass; sampled with start.
REQ-007 SHALL have port double_en, input, 1 bit: selects a second SHA-256 pass over the first digest; sampled with start.
REQ-008 SHALL have port work_valid, input, 1 bit: compression core presents final working variables a..h.
REQ-009 SHALL have port work_in, input, 256 bits: working variables; word i occupies bits [32i+31:32i], word 0 = a.
REQ-010 SHALL have port work_ready, output, 1 bit: the bank accepts a work beat.
REQ-011 SHALL have port chain_out, output, 256 bits: current chaining value (H0..H7) for core initialisation.
REQ-012 SHALL have port mid_out, output, 256 bits: the first-pass digest, which is the message for the second pass.
REQ-013 SHALL have port phase, output, 1 bit: 0 = first pass, 1 = second pass.
REQ-014 SHALL have port digest_out, output, 256 bits: final digest.
REQ-015 SHALL have port digest_valid, output, 1 bit: final digest available; held until accepted.
REQ-016 SHALL have port digest_ready, input, 1 bit: consumer accepts the digest.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal start.

Function
REQ-019 SHALL implement the FSM states IDLE, PASS1, PASS2 and DONE.
REQ-020 IDLE: chain_out SHALL equal IV (word0 = 32'h6a09e667 ... word7 = 32'h5be0cd19) and work_ready SHALL be 0.
REQ-021 IDLE plus start with 1 <= nblocks <= MAX_BLOCKS SHALL latch nblocks and double_en, clear blk_cnt and move to PASS1.
REQ-022 IDLE plus start with nblocks = 0 or nblocks > MAX_BLOCKS SHALL pulse err for one cycle and remain in IDLE.
REQ-023 PASS1 and PASS2 SHALL assert work_ready; a beat is accepted when work_valid and work_ready are both 1.
REQ-024 Each accepted beat SHALL update every word as chain[i] <= chain[i] + work_in[i], modulo 2^32, with the carry discarded per word.
REQ-025 In PASS1, an accepted beat with blk_cnt < nblocks-1 SHALL increment blk_cnt and stay in PASS1.
REQ-026 In PASS1, the last beat with double mode active SHALL load mid_out <= chain + work_in, set chain <= IV and phase <= 1, and move to PASS2.
REQ-027 In PASS1, the last beat with double mode inactive SHALL load digest_out <= chain + work_in and move to DONE.
REQ-028 In PASS2, one accepted beat SHALL load digest_out <= IV + work_in and move to DONE; the second pass is always exactly one block.
REQ-029 digest_valid SHALL rise the cycle after the final accepted beat (latency 1) and SHALL be asserted only in DONE.
REQ-030 In DONE, work_ready SHALL be 0; digest_ready SHALL return the FSM to IDLE, reload IV and clear phase.
REQ-031 start SHALL be ignored when busy = 1, including when start and digest_ready occur in the same DONE cycle; that cycle goes to IDLE only.
REQ-032 work_valid SHALL be ignored while work_ready = 0.
REQ-033 digest_out and mid_out SHALL hold their values until the next overwrite.

Reset
REQ-034 Asserting rst_n low SHALL take effect immediately, at any time including mid-pass.
REQ-035 On reset: state = IDLE, chain = IV, mid_out = 0, digest_out = 0, blk_cnt = 0, phase = 0, and digest_valid, work_ready, err and busy all = 0.

Structure
REQ-036 Package sha256_pkg SHALL hold WORD_W = 32, NUM_WORDS = 8, the IV constant array and the FSM state typedef.
REQ-037 Sub-module hash_word_acc SHALL be one 32-bit chaining word: IV load, modular add and hold; it is instantiated 8 times via generate.

Verification
REQ-038 The bench SHALL drive start with nblocks = 1, double_en = 0 and one beat of work_in = 0 -> digest_out = IV, with digest_valid high one cycle later.
REQ-039 The bench SHALL drive a single block with work_in word7 = 32'ha41f32e7 and all other words 0 -> digest word7 = 32'h00000000 (wrap), with the other words equal to IV.
REQ-040 The bench SHALL drive nblocks = 2, double_en = 1 and three beats of all-ones words -> mid_out[i] = IV[i] - 2 mod 2^32 and digest_out[i] = IV[i] - 1, with phase = 1 during the third beat.
REQ-041 The bench SHALL drive start with nblocks = 0 and, separately, nblocks = 5 -> err pulses one cycle, busy stays 0 and the FSM stays in IDLE.
REQ-042 The bench SHALL hold digest_ready = 0 for 5 cycles in DONE while pulsing start and work_valid -> digest_valid and digest_out are held and chain is unchanged; asserting digest_ready then returns the FSM to IDLE.
REQ-043 The bench SHALL pull rst_n low during PASS2 -> outputs match REQ-035 immediately; a new message with nblocks = 1 afterwards completes correctly.
